bridge_host: RTL and testbench
==============================

BRIDGE_HOST -- requirements
Module: bridge_host

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, default 1_000_000, WAIT_RESP cycles before a read is abandoned.
REQ-002 SHALL have port: clk  input  1  single clock, all logic rising-edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: req_addr  input  16  request address.
REQ-005 SHALL have port: req_data  input  16  write data, ignored for reads.
REQ-006 SHALL have port: req_rw  input  1  1=write, 0=read.
REQ-007 SHALL have port: req_valid  input  1  request offered.
REQ-008 SHALL have port: req_ready  output  1  request accepted when high with req_valid.
REQ-009 SHALL have port: axiod  output  8  outgoing ASCII byte to uart_tx.
REQ-010 SHALL have port: axiov  output  1  outgoing byte valid.
REQ-011 SHALL have port: axior  input  1  uart_tx ready; byte transfers on axiov && axior.
REQ-012 SHALL have port: axiid  input  8  incoming ASCII byte from uart_rx.
REQ-013 SHALL have port: axiiv  input  1  incoming byte valid, single-cycle, no backpressure.
REQ-014 SHALL have port: res_data  output  16  read result, valid with res_valid.
REQ-015 SHALL have port: res_valid  output  1  one-cycle pulse, read completed.
REQ-016 SHALL have port: res_error  output  1  one-cycle pulse, read failed (malformed or timeout).

Function
REQ-017 SHALL use states IDLE, SEND, WAIT_RESP; req_ready SHALL be high only in IDLE.
REQ-018 SHALL capture addr/data/rw on req_valid && req_ready and enter SEND; axiov SHALL rise the next cycle.
REQ-019 SHALL emit read as 7 bytes: 'R', 4 addr hex digits MSB-first, CR (0x0D), LF (0x0A).
REQ-020 SHALL emit write as 11 bytes: 'W', 4 addr hex digits, 4 data hex digits, CR, LF.
REQ-021 SHALL encode hex as uppercase ASCII ('0'-'9', 'A'-'F').
REQ-022 SHALL hold axiod stable and axiov high until axior; SHALL advance one byte per transfer, no gaps required.
REQ-023 After write LF transfer, SHALL return to IDLE next cycle, no response expected.
REQ-024 After read LF transfer, SHALL enter WAIT_RESP with parser index 0 and timeout counter 0.
REQ-025 In WAIT_RESP, SHALL accept exactly 'M', 4 uppercase hex digits (MSB-first), CR, LF.
REQ-026 SHALL pulse res_valid with assembled res_data the cycle after LF is received, then IDLE.
REQ-027 Any unexpected byte in WAIT_RESP SHALL pulse res_error next cycle, return to IDLE.
REQ-028 Timeout counter SHALL reach TIMEOUT_CYCLES -> res_error pulse, IDLE; counter does not reset on received bytes.
REQ-029 Bytes on axiiv outside WAIT_RESP SHALL be ignored.
REQ-030 res_valid and res_error SHALL never be high together; res_data SHALL hold last value between reads.

Reset
REQ-031 rst low at a clock edge SHALL force IDLE; axiov, res_valid, res_error = 0; res_data, axiod = 0; req_ready = 1 after release.
REQ-032 Reset mid-SEND SHALL drop the frame; axiov low the cycle after the reset edge.
REQ-033 Reset mid-WAIT_RESP SHALL discard partial response, produce no pulse.

Structure
REQ-034 ASCII constants ('R','W','M',CR,LF) and frame lengths SHALL live in shared package bridge_pkg, also used by bridge_rx/bridge_tx.
REQ-035 Nibble<->ASCII conversion SHALL be in sub-module hex_codec (combinational encode, decode with invalid flag).

Verification
REQ-036 Read 0x1234, axior=1 -> bytes "R1234\r\n"; then feed "MBEEF\r\n" -> res_valid, res_data=0xBEEF.
REQ-037 Write addr 0x00A5 data 0xC0DE, axior toggled every other cycle -> "W00A5C0DE\r\n", axiod stable while stalled, no res pulse.
REQ-038 Read, feed "M12G4\r\n" -> res_error one cycle after 'G', IDLE, req_ready=1.
REQ-039 TIMEOUT_CYCLES=16, read with no response -> res_error 16 cycles after WAIT_RESP entry.
REQ-040 rst low during 4th byte of a write -> axiov low next cycle; next read sends full "R0007\r\n" cleanly.
REQ-041 Bytes "M0001\r\n" injected while IDLE -> no res_valid; req_valid during SEND -> not accepted until IDLE.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared constants and types for the ASCII UART bridge (host, rx and tx sides).
package bridge_pkg;

  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned NIB_W    = 4;
  localparam int unsigned IDX_W    = 4;

  localparam int unsigned RD_LEN   = 7;
  localparam int unsigned WR_LEN   = 11;
  localparam int unsigned RESP_LEN = 7;

  localparam logic [BYTE_W-1:0] ASCII_R  = 8'h52;
  localparam logic [BYTE_W-1:0] ASCII_W  = 8'h57;
  localparam logic [BYTE_W-1:0] ASCII_M  = 8'h4D;
  localparam logic [BYTE_W-1:0] ASCII_CR = 8'h0D;
  localparam logic [BYTE_W-1:0] ASCII_LF = 8'h0A;
  localparam logic [BYTE_W-1:0] ASCII_0  = 8'h30;
  localparam logic [BYTE_W-1:0] ASCII_9  = 8'h39;
  localparam logic [BYTE_W-1:0] ASCII_A  = 8'h41;
  localparam logic [BYTE_W-1:0] ASCII_F  = 8'h46;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_RESP
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              rw;
  } req_t;

  // Index of the LF byte in an outgoing frame.
  function automatic logic [IDX_W-1:0] frame_last(input logic rw);
    return rw ? IDX_W'(WR_LEN - 1) : IDX_W'(RD_LEN - 1);
  endfunction

endpackage

// File: rtl/hex_codec.sv
// Nibble <-> uppercase ASCII hex conversion, purely combinational.
module hex_codec
  import bridge_pkg::*;
(
  input  logic [NIB_W-1:0]  enc_nibble,
  output logic [BYTE_W-1:0] enc_ascii_c,
  input  logic [BYTE_W-1:0] dec_ascii,
  output logic [NIB_W-1:0]  dec_nibble_c,
  output logic              dec_invalid_c
);

  always_comb begin : encode
    enc_ascii_c = ASCII_0 + BYTE_W'(enc_nibble);
    if (enc_nibble >= NIB_W'(10)) begin
      enc_ascii_c = ASCII_A + BYTE_W'(enc_nibble) - BYTE_W'(10);
    end
  end

  // Lowercase hex is deliberately rejected.
  always_comb begin : decode
    dec_nibble_c  = '0;
    dec_invalid_c = 1'b1;
    if (dec_ascii >= ASCII_0 && dec_ascii <= ASCII_9) begin
      dec_nibble_c  = dec_ascii[NIB_W-1:0];
      dec_invalid_c = 1'b0;
    end else if (dec_ascii >= ASCII_A && dec_ascii <= ASCII_F) begin
      dec_nibble_c  = dec_ascii[NIB_W-1:0] + NIB_W'(9);
      dec_invalid_c = 1'b0;
    end
  end

endmodule

// File: rtl/bridge_host.sv
// Host-side bridge: serialises read/write requests into ASCII frames for a UART
// and parses the "Mhhhh\r\n" reply that completes a read.
module bridge_host
  import bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic              req_rw,
  input  logic              req_valid,
  output logic              req_ready,
  output logic [BYTE_W-1:0] axiod,
  output logic              axiov,
  input  logic              axior,
  input  logic [BYTE_W-1:0] axiid,
  input  logic              axiiv,
  output logic [DATA_W-1:0] res_data,
  output logic              res_valid,
  output logic              res_error
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t            state_q, state_d;
  req_t              req_q, req_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BYTE_W-1:0] axiod_q;
  logic              axiov_q, axiov_d;
  logic              req_ready_q;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              res_valid_q, res_valid_d;
  logic              res_error_q, res_error_d;

  logic              tx_load;
  logic [NIB_W-1:0]  tx_nib;
  logic              tx_hex;
  logic [BYTE_W-1:0] tx_byte;
  logic [BYTE_W-1:0] enc_ascii_c;
  logic [NIB_W-1:0]  rx_nib_c;
  logic              rx_nib_invalid_c;
  logic              rx_bad;

  hex_codec u_hex_codec (
    .enc_nibble    (tx_nib),
    .enc_ascii_c   (enc_ascii_c),
    .dec_ascii     (axiid),
    .dec_nibble_c  (rx_nib_c),
    .dec_invalid_c (rx_nib_invalid_c)
  );

  // Nibble feeding the byte that will be presented next (index idx_d of req_d).
  always_comb begin : tx_nib_sel
    tx_nib = '0;
    tx_hex = 1'b0;
    case (idx_d)
      IDX_W'(1): begin tx_nib = req_d.addr[15:12]; tx_hex = 1'b1;     end
      IDX_W'(2): begin tx_nib = req_d.addr[11:8];  tx_hex = 1'b1;     end
      IDX_W'(3): begin tx_nib = req_d.addr[7:4];   tx_hex = 1'b1;     end
      IDX_W'(4): begin tx_nib = req_d.addr[3:0];   tx_hex = 1'b1;     end
      IDX_W'(5): begin tx_nib = req_d.data[15:12]; tx_hex = req_d.rw; end
      IDX_W'(6): begin tx_nib = req_d.data[11:8];  tx_hex = req_d.rw; end
      IDX_W'(7): begin tx_nib = req_d.data[7:4];   tx_hex = req_d.rw; end
      IDX_W'(8): begin tx_nib = req_d.data[3:0];   tx_hex = req_d.rw; end
      default: ;
    endcase
  end

  always_comb begin : tx_byte_sel
    tx_byte = ASCII_LF;
    if (idx_d == '0) begin
      tx_byte = req_d.rw ? ASCII_W : ASCII_R;
    end else if (tx_hex) begin
      tx_byte = enc_ascii_c;
    end else if (idx_d != frame_last(req_d.rw)) begin
      tx_byte = ASCII_CR;
    end
  end

  // Whether the incoming byte breaks the expected reply at parser position idx_q.
  always_comb begin : rx_check
    rx_bad = 1'b1;
    case (idx_q)
      IDX_W'(0):                                    rx_bad = (axiid != ASCII_M);
      IDX_W'(1), IDX_W'(2), IDX_W'(3), IDX_W'(4):   rx_bad = rx_nib_invalid_c;
      IDX_W'(5):                                    rx_bad = (axiid != ASCII_CR);
      IDX_W'(6):                                    rx_bad = (axiid != ASCII_LF);
      default: ;
    endcase
  end

  always_comb begin : fsm_comb
    state_d     = state_q;
    req_d       = req_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    axiov_d     = axiov_q;
    res_data_d  = res_data_q;
    res_valid_d = 1'b0;
    res_error_d = 1'b0;
    tx_load     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_d   = '{addr: req_addr, data: req_data, rw: req_rw};
          idx_d   = '0;
          tx_load = 1'b1;
          axiov_d = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (axior) begin
          if (idx_q == frame_last(req_q.rw)) begin
            axiov_d = 1'b0;
            idx_d   = '0;
            cnt_d   = '0;
            acc_d   = '0;
            state_d = req_q.rw ? IDLE : WAIT_RESP;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            tx_load = 1'b1;
          end
        end
      end
      WAIT_RESP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (axiiv && rx_bad) begin
          res_error_d = 1'b1;
          state_d     = IDLE;
        end else if (axiiv && idx_q == IDX_W'(RESP_LEN - 1)) begin
          res_valid_d = 1'b1;
          res_data_d  = acc_q;
          state_d     = IDLE;
        end else begin
          if (axiiv) begin
            idx_d = idx_q + IDX_W'(1);
            if (idx_q >= IDX_W'(1) && idx_q <= IDX_W'(4)) begin
              acc_d = {acc_q[DATA_W-NIB_W-1:0], rx_nib_c};
            end
          end
          // The timeout runs from WAIT_RESP entry regardless of traffic.
          if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            res_error_d = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin : regs
    if (!rst) begin
      state_q     <= IDLE;
      req_q       <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      axiod_q     <= '0;
      axiov_q     <= 1'b0;
      req_ready_q <= 1'b1;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      res_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      axiov_q     <= axiov_d;
      req_ready_q <= (state_d == IDLE);
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      res_error_q <= res_error_d;
      if (tx_load) begin
        axiod_q <= tx_byte;
      end
    end
  end

  assign req_ready = req_ready_q;
  assign axiod     = axiod_q;
  assign axiov     = axiov_q;
  assign res_data  = res_data_q;
  assign res_valid = res_valid_q;
  assign res_error = res_error_q;

endmodule

// File: tb/tb_bridge_host.sv
// Bench for bridge_host: directed table of frames and replies, multi-cycle reset and
// flow-control sequences, then randomized traffic checked against a frame/reply model.
module tb_bridge_host;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_data = '0;
  logic        req_rw = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  axiod;
  logic        axiov;
  logic        axior = 1'b0;
  logic [7:0]  axiid = '0;
  logic        axiiv = 1'b0;
  logic [15:0] res_data;
  logic        res_valid;
  logic        res_error;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] last_res = '0;
  logic [7:0]  rb[7];
  int          rg[7];

  typedef struct {
    bit          rw;
    logic [15:0] addr;
    logic [15:0] data;
    int          mode;
    logic [55:0] resp;
    int          nfeed;
    int          gap;
    int          ekind;
    logic [15:0] edata;
  } vec_t;

  vec_t tbl[11];

  bridge_host #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_rw    (req_rw),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .axiod     (axiod),
    .axiov     (axiov),
    .axior     (axior),
    .axiid     (axiid),
    .axiiv     (axiiv),
    .res_data  (res_data),
    .res_valid (res_valid),
    .res_error (res_error)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] hexch(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  function automatic bit is_hex(input logic [7:0] b);
    return (b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h46);
  endfunction

  function automatic logic [3:0] hexval(input logic [7:0] b);
    return (b <= 8'h39) ? 4'(b - 8'h30) : 4'(b - 8'h37);
  endfunction

  function automatic bit resp_ok(input logic [7:0] b, input int p);
    if (p == 0) return b == 8'h4D;
    if (p <= 4) return is_hex(b);
    if (p == 5) return b == 8'h0D;
    return b == 8'h0A;
  endfunction

  // Reply outcome: kind 1 = result, 2 = error; 'at' is the WAIT_RESP cycle it is decided in.
  function automatic void model_resp(input int nfeed, output int kind, output logic [15:0] val,
                                     output int at);
    int bi;
    int nxt;
    logic [15:0] acc;
    bi = 0;
    acc = '0;
    kind = 2;
    val = '0;
    at = TO - 1;
    nxt = (nfeed > 0) ? rg[0] : -1;
    for (int k = 0; k < TO; k++) begin
      if (bi < nfeed && k == nxt) begin
        if (!resp_ok(rb[bi], bi)) begin kind = 2; at = k; return; end
        if (bi >= 1 && bi <= 4) acc = acc * 16 + {12'h0, hexval(rb[bi])};
        if (bi == 6) begin kind = 1; val = acc; at = k; return; end
        bi++;
        if (bi < nfeed) nxt = k + 1 + rg[bi];
      end
      if (k == TO - 1) begin kind = 2; at = k; return; end
    end
  endfunction

  task automatic issue(input bit rw, input logic [15:0] a, input logic [15:0] d);
    int b;
    b = 0;
    while (req_ready !== 1'b1 && b < 100) begin step(); b++; end
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_rw = rw; req_addr = a; req_data = d;
    step();
    req_valid = 1'b0;
    req_addr = 16'($urandom); req_data = 16'($urandom); req_rw = 1'($urandom_range(0, 1));
    check("axiov_rise", axiov, 1);
  endtask

  // Drains one outgoing frame; stop_at >= 0 returns while that byte index is presented.
  task automatic send_frame(input bit rw, input logic [15:0] a, input logic [15:0] d,
                            input int mode, input int stop_at);
    logic [7:0] fb[11];
    int len;
    int idx;
    int cyc;
    fb[0] = rw ? 8'h57 : 8'h52;
    for (int i = 0; i < 4; i++) fb[1+i] = hexch(4'(a >> (12 - 4 * i)));
    for (int i = 0; i < 4; i++) fb[5+i] = hexch(4'(d >> (12 - 4 * i)));
    len = rw ? 11 : 7;
    fb[len-2] = 8'h0D;
    fb[len-1] = 8'h0A;
    idx = 0;
    cyc = 0;
    while (idx < len && idx != stop_at && cyc < 200) begin
      check("tx_valid", axiov, 1);
      check("tx_byte", axiod, fb[idx]);
      check("tx_ready_low", req_ready, 0);
      check("tx_no_res", res_valid | res_error, 0);
      case (mode)
        0: axior = 1'b1;
        1: axior = (cyc % 2 == 1);
        default: axior = 1'($urandom_range(0, 1));
      endcase
      step();
      if (axior) idx++;
      cyc++;
    end
    axior = 1'b0;
    check("tx_done", idx, (stop_at < 0) ? len : stop_at);
    if (stop_at < 0) begin
      check("tx_end_valid", axiov, 0);
      check("ready_after_tx", req_ready, rw);
    end
  endtask

  task automatic run_resp(input int nfeed, output int kind_obs);
    int kind;
    int at;
    int bi;
    int nxt;
    logic [15:0] val;
    model_resp(nfeed, kind, val, at);
    kind_obs = 0;
    bi = 0;
    nxt = (nfeed > 0) ? rg[0] : -1;
    for (int k = 0; k <= at + 1; k++) begin
      if (k > 0) begin
        check("res_valid", res_valid, (k - 1 == at) && (kind == 1));
        check("res_error", res_error, (k - 1 == at) && (kind == 2));
        if (res_valid) kind_obs = 1;
        if (res_error) kind_obs = 2;
      end
      if (k == at + 1) begin
        if (kind == 1) last_res = val;
        check("res_data", res_data, last_res);
        check("ready_after_res", req_ready, 1);
      end else begin
        axiiv = 1'b0;
        if (bi < nfeed && k == nxt) begin
          axiiv = 1'b1;
          axiid = rb[bi];
          bi++;
          if (bi < nfeed) nxt = k + 1 + rg[bi];
        end
        step();
      end
    end
    axiiv = 1'b0;
  endtask

  task automatic idle_quiet(input int n);
    for (int i = 0; i < n; i++) begin
      check("idle_no_res", res_valid | res_error, 0);
      check("idle_res_data", res_data, last_res);
      step();
    end
  endtask

  initial begin
    int kobs;
    logic [7:0] junk[7];
    logic [15:0] v;
    int sel;
    int nf;
    bit rw;

    tbl[0]  = '{1'b0, 16'h1234, 16'h0000, 0, {"MBEEF", 8'h0D, 8'h0A}, 7, 0, 1, 16'hBEEF};
    tbl[1]  = '{1'b1, 16'h00A5, 16'hC0DE, 1, 56'h0,                   0, 0, 0, 16'hBEEF};
    tbl[2]  = '{1'b0, 16'h0001, 16'h0000, 0, {"M12G4", 8'h0D, 8'h0A}, 7, 0, 2, 16'hBEEF};
    tbl[3]  = '{1'b0, 16'hFFFF, 16'h0000, 2, {"M0000", 8'h0D, 8'h0A}, 7, 0, 1, 16'h0000};
    tbl[4]  = '{1'b0, 16'h0A0B, 16'h0000, 0, {"Mabcd", 8'h0D, 8'h0A}, 7, 0, 2, 16'h0000};
    tbl[5]  = '{1'b0, 16'h1111, 16'h0000, 1, {"XFFFF", 8'h0D, 8'h0A}, 7, 0, 2, 16'h0000};
    tbl[6]  = '{1'b0, 16'h2222, 16'h0000, 0, {"M9A0F", 8'h0D, 8'h0A}, 7, 1, 1, 16'h9A0F};
    tbl[7]  = '{1'b0, 16'h3333, 16'h0000, 0, {"MFFFF", 8'h0A, 8'h0D}, 7, 0, 2, 16'h9A0F};
    tbl[8]  = '{1'b0, 16'h4444, 16'h0000, 0, 56'h0,                   0, 0, 2, 16'h9A0F};
    tbl[9]  = '{1'b1, 16'hFFFF, 16'h0000, 2, 56'h0,                   0, 0, 0, 16'h9A0F};
    tbl[10] = '{1'b0, 16'h0000, 16'h0000, 0, {"MFFFF", 8'h0D, 8'h0A}, 7, 0, 1, 16'hFFFF};

    // Reset state
    step(); step();
    check("rst_axiov", axiov, 0);
    check("rst_axiod", axiod, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_error", res_error, 0);
    check("rst_res_data", res_data, 0);
    rst = 1'b1;
    step();
    check("rst_req_ready", req_ready, 1);

    // Reply bytes while idle are ignored
    junk[0] = 8'h4D; junk[1] = 8'h30; junk[2] = 8'h30; junk[3] = 8'h30;
    junk[4] = 8'h31; junk[5] = 8'h0D; junk[6] = 8'h0A;
    for (int i = 0; i < 7; i++) begin
      axiiv = 1'b1; axiid = junk[i];
      step();
      check("idle_junk_res", res_valid | res_error, 0);
      check("idle_junk_ready", req_ready, 1);
    end
    axiiv = 1'b0;
    idle_quiet(2);

    // Directed table
    foreach (tbl[i]) begin
      issue(tbl[i].rw, tbl[i].addr, tbl[i].data);
      send_frame(tbl[i].rw, tbl[i].addr, tbl[i].data, tbl[i].mode, -1);
      if (tbl[i].rw) begin
        idle_quiet(3);
        check("tbl_wr_data", res_data, tbl[i].edata);
      end else begin
        for (int j = 0; j < 7; j++) begin
          rb[j] = tbl[i].resp[55 - 8 * j -: 8];
          rg[j] = tbl[i].gap;
        end
        run_resp(tbl[i].nfeed, kobs);
        check("tbl_kind", kobs, tbl[i].ekind);
        check("tbl_data", res_data, tbl[i].edata);
      end
    end

    // Request held during SEND is only taken once back in IDLE
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 16'h0101; req_data = 16'h0202;
    step();
    req_addr = 16'h0303; req_data = 16'h0404;
    send_frame(1'b1, 16'h0101, 16'h0202, 0, -1);
    step();
    req_valid = 1'b0;
    check("held_req_taken", axiov, 1);
    send_frame(1'b1, 16'h0303, 16'h0404, 1, -1);
    idle_quiet(2);

    // Reset while the 4th byte of a write is presented
    issue(1'b1, 16'h1234, 16'hABCD);
    send_frame(1'b1, 16'h1234, 16'hABCD, 0, 3);
    rst = 1'b0; axior = 1'b1;
    step();
    check("rst_tx_axiov", axiov, 0);
    check("rst_tx_axiod", axiod, 0);
    check("rst_tx_ready", req_ready, 1);
    rst = 1'b1; axior = 1'b0;
    last_res = '0;
    step();
    check("post_rst_axiov", axiov, 0);
    issue(1'b0, 16'h0007, 16'h0000);
    send_frame(1'b0, 16'h0007, 16'h0000, 0, -1);
    rb[0] = 8'h4D; rb[1] = 8'h30; rb[2] = 8'h30; rb[3] = 8'h41; rb[4] = 8'h42;
    rb[5] = 8'h0D; rb[6] = 8'h0A;
    for (int j = 0; j < 7; j++) rg[j] = 0;
    run_resp(7, kobs);
    check("post_rst_read", res_data, 16'h00AB);

    // Reset mid-reply discards it without a pulse
    issue(1'b0, 16'h5555, 16'h0000);
    send_frame(1'b0, 16'h5555, 16'h0000, 0, -1);
    for (int i = 0; i < 3; i++) begin
      axiiv = 1'b1; axiid = junk[i];
      step();
    end
    axiiv = 1'b0; rst = 1'b0;
    step();
    rst = 1'b1;
    last_res = '0;
    check("rst_rx_data", res_data, 0);
    idle_quiet(TO + 4);

    // Randomized traffic
    for (int n = 0; n < 30; n++) begin
      rw = 1'($urandom_range(0, 1));
      req_addr = 16'($urandom);
      v = req_addr;
      issue(rw, v, ~v ^ 16'h5A5A);
      send_frame(rw, v, ~v ^ 16'h5A5A, $urandom_range(0, 2), -1);
      if (rw) begin
        idle_quiet(2);
      end else begin
        v = 16'($urandom);
        rb[0] = 8'h4D;
        for (int j = 0; j < 4; j++) rb[1+j] = hexch(4'(v >> (12 - 4 * j)));
        rb[5] = 8'h0D; rb[6] = 8'h0A;
        sel = $urandom_range(0, 9);
        if (sel < 2) rb[$urandom_range(0, 6)] = 8'($urandom);
        for (int j = 0; j < 7; j++) rg[j] = (sel >= 8) ? $urandom_range(0, 4) : $urandom_range(0, 1);
        nf = (sel == 9) ? $urandom_range(0, 7) : 7;
        run_resp(nf, kobs);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
